// File: rtl/alu_controller_if.sv
// alu_controller_if
//   Bundles the request, shared-ALU and response signals of alu_controller.
//   slave  : the controller side (accepts requests, drives the ALU operands,
//            produces responses).
//   master : the requester / ALU / consumer side.
//   Ports (N = operand width):
//     req_valid/req_ready/req_op[3:0]/req_a[N]/req_b[N]  request channel
//     alu_a[N]/alu_b[N]/alu_s[3:0]                       operands to the ALU
//     alu_result[N]/alu_neg/alu_zr/alu_cry/alu_of        ALU result and flags
//     rsp_valid/rsp_ready/rsp_result[N]/rsp_* flags/err  response channel
//     busy                                               controller not idle
interface alu_controller_if #(parameter int N = 4);
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_s;
  logic [N-1:0] alu_result;
  logic         alu_neg;
  logic         alu_zr;
  logic         alu_cry;
  logic         alu_of;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_neg;
  logic         rsp_zr;
  logic         rsp_cry;
  logic         rsp_of;
  logic         rsp_err;
  logic         busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_a, alu_b, alu_s,
    input  alu_result, alu_neg, alu_zr, alu_cry, alu_of,
    output rsp_valid, rsp_result, rsp_neg, rsp_zr, rsp_cry, rsp_of, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_a, alu_b, alu_s,
    output alu_result, alu_neg, alu_zr, alu_cry, alu_of,
    input  rsp_valid, rsp_result, rsp_neg, rsp_zr, rsp_cry, rsp_of, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_controller.sv
// alu_controller
//   Sequences single requests onto a shared combinational ALU (ops 0-6) or
//   an internal iterative unit (7 mul, 8 div, 9 mod; N cycles each) and
//   returns one response per request. Opcodes 10-15 answer at once with err.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : alu_controller_if.slave (request, ALU and response signals)
//   Requires N >= 2.
module alu_controller #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_controller_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   res_q, res_d;
  logic           neg_q, neg_d, zr_q, zr_d, cry_q, cry_d, of_q, of_d, err_q, err_d;
  logic           rsp_valid_q, rsp_valid_d, busy_q, busy_d, ready_q, ready_d;

  // Iteration datapath. acc holds {high, low} halves:
  //   mul: {partial product, remaining multiplier bits}, shifted right each step
  //   div: {remainder, dividend/quotient bits}, shifted left each step
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_diff;
  logic [2*N-1:0] div_next;
  logic [2*N-1:0] step_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, (a_q & {N{acc_q[0]}})};
    mul_next  = {mul_sum, acc_q[N-1:1]};
    div_shift = acc_q[2*N-1:N-1];
    div_ge    = (div_shift >= {1'b0, b_q});
    // Only used when div_ge, where the true difference is below b and fits N bits.
    div_diff  = div_shift[N-1:0] - b_q;
    div_next  = {(div_ge ? div_diff : div_shift[N-1:0]), acc_q[N-2:0], div_ge};
    step_next = (op_q == 4'd7) ? mul_next : div_next;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    neg_d   = neg_q;
    zr_d    = zr_q;
    cry_d   = cry_q;
    of_d    = of_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          a_d   = bus.req_a;
          b_d   = bus.req_b;
          cnt_d = '0;
          if (bus.req_op <= 4'd6) begin
            state_d = EXEC;
          end else if (bus.req_op <= 4'd9) begin
            state_d = ITER;
            acc_d   = (bus.req_op == 4'd7) ? {{N{1'b0}}, bus.req_b}
                                           : {{N{1'b0}}, bus.req_a};
          end else begin
            state_d = DONE;
            res_d   = '0;
            neg_d   = 1'b0;
            zr_d    = 1'b0;
            cry_d   = 1'b0;
            of_d    = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        res_d   = bus.alu_result;
        neg_d   = bus.alu_neg;
        zr_d    = bus.alu_zr;
        cry_d   = bus.alu_cry;
        of_d    = bus.alu_of;
        err_d   = 1'b0;
        state_d = DONE;
      end
      ITER: begin
        acc_d = step_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cry_d   = 1'b0;
          of_d    = 1'b0;
          err_d   = 1'b0;
          if (op_q == 4'd7) begin
            res_d = step_next[N-1:0];
            of_d  = |step_next[2*N-1:N];
          end else if (op_q == 4'd8) begin
            res_d = step_next[N-1:0];
          end else begin
            res_d = step_next[2*N-1:N];
          end
          neg_d = res_d[N-1];
          zr_d  = (res_d == '0);
          // Division by zero still runs the full N steps, then overrides.
          if (op_q != 4'd7 && b_q == '0) begin
            res_d = (op_q == 4'd8) ? '1 : a_q;
            neg_d = 1'b0;
            zr_d  = 1'b0;
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    ready_d     = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      neg_q       <= 1'b0;
      zr_q        <= 1'b0;
      cry_q       <= 1'b0;
      of_q        <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      neg_q       <= neg_d;
      zr_q        <= zr_d;
      cry_q       <= cry_d;
      of_q        <= of_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_s      = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_neg    = neg_q;
  assign bus.rsp_zr     = zr_q;
  assign bus.rsp_cry    = cry_q;
  assign bus.rsp_of     = of_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller
//   Self-checking bench for alu_controller (N = 4) with a behavioural
//   shared-ALU model and a scoreboard queue of expected responses.
module tb_alu_controller;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_controller_if #(.N(N)) bus();
  alu_controller #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // v = {result[3:0], neg, zr, cry, of, err}
  typedef struct {
    logic [8:0] v;
    int         lat;
  } exp_t;
  exp_t sb[$];

  // Shared ALU: {result, neg, zr, cry, of}
  function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] w;
    logic [3:0] r;
    logic       c, o;
    w = '0; c = 1'b0; o = 1'b0;
    case (s)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; c = w[4]; o = (a[3] == b[3]) && (w[3] != a[3]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; c = w[4]; o = (a[3] != b[3]) && (w[3] != a[3]); end
      4'd2: w[3:0] = a & b;
      4'd3: w[3:0] = a | b;
      4'd4: w[3:0] = a ^ b;
      4'd5: w[3:0] = a << b;
      4'd6: w[3:0] = a >> b;
      default: w = '0;
    endcase
    r = w[3:0];
    return {r, r[3], (r == 4'd0), c, o};
  endfunction

  always_comb {bus.alu_result, bus.alu_neg, bus.alu_zr, bus.alu_cry, bus.alu_of} =
    alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

  function automatic exp_t model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t       e;
    logic [7:0] p;
    logic [3:0] r;
    if (op <= 4'd6) begin
      e.v = {alu_fn(op, a, b), 1'b0}; e.lat = 2;
    end else if (op == 4'd7) begin
      p = a * b; r = p[3:0];
      e.v = {r, r[3], (r == 4'd0), 1'b0, (p[7:4] != 4'd0), 1'b0}; e.lat = N + 1;
    end else if (op <= 4'd9) begin
      e.lat = N + 1;
      if (b == 4'd0) e.v = {((op == 4'd8) ? 4'hF : a), 4'b0000, 1'b1};
      else begin
        r = (op == 4'd8) ? a / b : a % b;
        e.v = {r, r[3], (r == 4'd0), 2'b00, 1'b0};
      end
    end else begin
      e.v = 9'b0_0000_0001; e.lat = 1;
    end
    return e;
  endfunction

  function automatic logic [8:0] rsp_vec();
    return {bus.rsp_result, bus.rsp_neg, bus.rsp_zr, bus.rsp_cry, bus.rsp_of, bus.rsp_err};
  endfunction

  // Drives one request, pushes its expectation, returns cycles until rsp_valid
  // (1 = visible right after the accept edge); 40 means it never came.
  task automatic send_req(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, output int lat);
    int k;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 40) begin @(negedge clk); k++; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int   lat;
    exp_t e;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_s, rsp_vec()} !==
        {3'b100, 12'h000, 9'h000}) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b alu=%h/%h/%h rsp=%b", bus.req_ready,
               bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_s, rsp_vec());
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    send_req(4'd0, 4'd2, 4'd3, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin errors++; $display("FAIL first_after_reset lat: got %0d want %0d", lat, e.lat); end
    checks++;
    if (rsp_vec() !== e.v) begin errors++; $display("FAIL first_after_reset rsp: got %b want %b", rsp_vec(), e.v); end
    finish_rsp();
  endtask

  task automatic test_add();
    int   lat;
    exp_t e;
    send_req(4'd0, 4'd7, 4'd9, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 2 || rsp_vec() !== 9'b0000_0_1_1_0_0) begin
      errors++; $display("FAIL add_7_9: lat %0d rsp %b want lat 2 rsp 000001100", lat, rsp_vec());
    end
    finish_rsp();
    for (int i = 0; i < 7; i++) begin
      send_req(4'(i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL alu_op%0d lat: got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (rsp_vec() !== e.v) begin errors++; $display("FAIL alu_op%0d rsp: got %b want %b", i, rsp_vec(), e.v); end
      finish_rsp();
    end
  endtask

  task automatic test_mul();
    int         lat;
    exp_t       e;
    logic [3:0] ta[5] = '{4'd5, 4'd6, 4'd15, 4'd0, 4'd9};
    logic [3:0] tb[5] = '{4'd3, 4'd3, 4'd15, 4'd9, 4'd1};
    for (int i = 0; i < 5; i++) begin
      send_req(4'd7, ta[i], tb[i], lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL mul%0d lat: got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (rsp_vec() !== e.v) begin errors++; $display("FAIL mul%0d rsp: got %b want %b", i, rsp_vec(), e.v); end
      if (i == 0) begin
        checks++;
        if (lat !== 5 || bus.rsp_result !== 4'hF || bus.rsp_of !== 1'b0) begin
          errors++; $display("FAIL mul_5_3: lat %0d res %h of %b want 5 F 0", lat, bus.rsp_result, bus.rsp_of);
        end
      end
      if (i == 1) begin
        checks++;
        if (bus.rsp_result !== 4'h2 || bus.rsp_of !== 1'b1) begin
          errors++; $display("FAIL mul_6_3: res %h of %b want 2 1", bus.rsp_result, bus.rsp_of);
        end
      end
      finish_rsp();
    end
  endtask

  task automatic test_div();
    int         lat;
    exp_t       e;
    logic [3:0] to[6] = '{4'd8, 4'd9, 4'd8, 4'd9, 4'd8, 4'd9};
    logic [3:0] ta[6] = '{4'd13, 4'd13, 4'd9, 4'd9, 4'd15, 4'd7};
    logic [3:0] tb[6] = '{4'd4, 4'd4, 4'd0, 4'd0, 4'd1, 4'd9};
    logic [4:0] want[4] = '{5'b0011_0, 5'b0001_0, 5'b1111_1, 5'b1001_1};
    for (int i = 0; i < 6; i++) begin
      send_req(to[i], ta[i], tb[i], lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL div%0d lat: got %0d want %0d", i, lat, e.lat); end
      checks++;
      if (rsp_vec() !== e.v) begin errors++; $display("FAIL div%0d rsp: got %b want %b", i, rsp_vec(), e.v); end
      if (i < 4) begin
        checks++;
        if ({bus.rsp_result, bus.rsp_err} !== want[i]) begin
          errors++; $display("FAIL div_directed%0d: got %b want %b", i, {bus.rsp_result, bus.rsp_err}, want[i]);
        end
      end
      finish_rsp();
    end
  endtask

  task automatic test_illegal();
    int         lat;
    exp_t       e;
    logic [3:0] to[3] = '{4'd12, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      send_req(to[i], 4'd5, 4'd3, lat);
      e = sb.pop_front();
      checks++;
      if (lat !== 1 || rsp_vec() !== 9'b0000_0000_1) begin
        errors++; $display("FAIL illegal_op%0d: lat %0d rsp %b want lat 1 rsp 000000001", to[i], lat, rsp_vec());
      end
      checks++;
      if (lat !== e.lat || rsp_vec() !== e.v) begin
        errors++; $display("FAIL illegal_sb%0d: lat %0d rsp %b want %0d %b", i, lat, rsp_vec(), e.lat, e.v);
      end
      finish_rsp();
    end
  endtask

  task automatic test_backpressure();
    int         lat;
    exp_t       e;
    logic [8:0] snap;
    send_req(4'd0, 4'd3, 4'd4, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rsp_vec() !== e.v) begin
      errors++; $display("FAIL bp_first: lat %0d rsp %b want %0d %b", lat, rsp_vec(), e.lat, e.v);
    end
    snap = e.v;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd7; bus.req_a = 4'd2; bus.req_b = 4'd3;
    sb.push_back(model(4'd7, 4'd2, 4'd3));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_vec(), bus.rsp_valid, bus.req_ready, bus.busy} !== {snap, 3'b101}) begin
        errors++; $display("FAIL bp_hold%0d: rsp %b v/r/b %b%b%b want %b 101", i, rsp_vec(),
                           bus.rsp_valid, bus.req_ready, bus.busy, snap);
      end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.busy} !== 3'b010) begin
      errors++; $display("FAIL bp_no_accept_on_handshake: v/r/b %b%b%b want 010", bus.rsp_valid, bus.req_ready, bus.busy);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.req_ready, bus.busy} !== 2'b01) begin
      errors++; $display("FAIL bp_accept_next: r/b %b%b want 01", bus.req_ready, bus.busy);
    end
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rsp_vec() !== e.v) begin
      errors++; $display("FAIL bp_pending: lat %0d rsp %b want %0d %b", lat, rsp_vec(), e.lat, e.v);
    end
    finish_rsp();
  endtask

  task automatic test_reset_iter();
    int   lat;
    exp_t e;
    logic seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 4'd7; bus.req_a = 4'd7; bus.req_b = 4'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_s, rsp_vec()} !==
        {3'b100, 12'h000, 9'h000}) begin
      errors++;
      $display("FAIL reset_in_iter: ready=%b valid=%b busy=%b alu=%h/%h/%h rsp=%b", bus.req_ready,
               bus.rsp_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_s, rsp_vec());
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (N + 3) begin @(posedge clk); #1; seen = seen | bus.rsp_valid | bus.busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_abandon: activity seen %b want 0", seen); end
    send_req(4'd7, 4'd6, 4'd3, lat);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rsp_vec() !== e.v) begin
      errors++; $display("FAIL after_reset_mul: lat %0d rsp %b want %0d %b", lat, rsp_vec(), e.lat, e.v);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int         lat;
    exp_t       e;
    logic [3:0] op;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 15));
      send_req(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), lat);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rsp_vec() !== e.v) begin
        errors++; $display("FAIL b2b%0d op%0d: lat %0d rsp %b want %0d %b", i, op, lat, rsp_vec(), e.lat, e.v);
      end
      finish_rsp();
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 4'd0;
    bus.req_b     = 4'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_illegal();
    test_backpressure();
    test_reset_iter();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_controller.md
ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 The block SHALL have parameter N, default 4, which sets the operand and result width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shift left, 6 shift right, 7 mul, 8 div, 9 mod; 10-15 illegal
- req_a, req_b  in  N  unsigned operands
- alu_a, alu_b  out  N  operands driven to the shared ALU
- alu_s  out  4  ALU select
- alu_result  in  N  ALU result
- alu_neg, alu_zr, alu_cry, alu_of  in  1 each  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  N  result
- rsp_neg, rsp_zr, rsp_cry, rsp_of  out  1 each  response flags
- rsp_err  out  1  illegal opcode or divide by zero
- busy  out  1  state not IDLE

Function
REQ-003 The block SHALL have four states: IDLE, EXEC, ITER, DONE.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge with req_valid=1 and req_ready=1.
REQ-005 On acceptance, the block SHALL register req_op, req_a and req_b, then go to the next state by opcode:
- 0-6: go to EXEC.
- 7-9: go to ITER with the iteration counter set to 0.
- 10-15: go to DONE with rsp_result=0, all flags 0 and rsp_err=1.
REQ-006 alu_a, alu_b and alu_s SHALL always reflect the registered operands and opcode, and SHALL hold their last values outside EXEC.
REQ-007 EXEC SHALL last exactly one cycle; at its closing edge the block SHALL capture alu_result and the four ALU flags into the rsp_* registers, set rsp_err=0, and go to DONE.
REQ-008 ITER SHALL last exactly N cycles, performing one shift-add (mul) or one restoring-divide (div/mod) step per cycle, then go to DONE.
REQ-009 For mul:
- rsp_result = low N bits of a*b
- rsp_of = 1 if the high N bits are nonzero
- rsp_zr = (rsp_result == 0)
- rsp_neg = rsp_result[N-1]
- rsp_cry = 0
REQ-010 For div, rsp_result SHALL be the unsigned quotient; for mod, it SHALL be the remainder; zr and neg follow the REQ-009 rule, and cry = of = 0.
REQ-011 When b == 0 for div or mod, the block SHALL still spend N cycles in ITER, then return:
- div: rsp_result = all ones, rsp_err = 1
- mod: rsp_result = a, rsp_err = 1
- all flags 0
REQ-012 Response timing relative to an accept edge T:
- ops 0-6: rsp_valid first high in cycle T+2
- ops 7-9: rsp_valid first high in cycle T+N+1
- illegal ops: rsp_valid first high in cycle T+1
REQ-013 In DONE, rsp_valid SHALL be 1 and all rsp_* outputs SHALL be held stable until an edge with rsp_ready=1, at which point the block SHALL return to IDLE.
REQ-014 A new request SHALL NOT be accepted in the same cycle as a response handshake; it is accepted earliest on the following edge.
REQ-015 rsp_valid SHALL be 0 in every state other than DONE.
REQ-016 busy SHALL be 1 whenever the state is not IDLE.

Reset
REQ-017 While rst_n=0, the block SHALL immediately, and independent of clk, force:
- state to IDLE
- all registered operands, alu_a, alu_b, alu_s and all rsp_* outputs to 0
- rsp_valid = 0, busy = 0, req_ready = 1
REQ-018 A reset asserted in EXEC, ITER or DONE SHALL abandon the operation with no response.
REQ-019 After rst_n is released, the first request SHALL be acceptable on the first rising edge.

Verification (N=4)
REQ-020 The bench SHALL cover these directed scenarios:
- Add 7+9 with the ALU model returning 0, cry=1, zr=1 -> rsp_valid at T+2, rsp_result=0, rsp_cry=1, rsp_zr=1, rsp_err=0.
- Mul 5*3 -> rsp_result=4'hF, rsp_of=0, rsp_valid at T+5; mul 6*3 -> rsp_result=4'h2, rsp_of=1.
- Div 13/4 -> rsp_result=3; mod 13/4 -> rsp_result=1; div 9/0 -> rsp_result=4'hF, rsp_err=1; mod 9/0 -> rsp_result=9, rsp_err=1.
- Illegal op 12 -> rsp_valid at T+1, rsp_err=1, rsp_result=0.
- rsp_ready held low 3 cycles in DONE -> rsp_* stable, req_ready=0, a pending req_valid is not accepted until the edge after the response handshake.
- rst_n pulsed low during cycle 2 of ITER -> outputs zero immediately, no response, next request completes normally.
